// File: rtl/multicycle_control_fsm_pkg.sv
// Shared opcode constants, state encodings and immediate-format decode
// for the multicycle RISC-V control path.
package multicycle_control_fsm_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECUTEI = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    function automatic logic [1:0] imm_src(input logic [6:0] op);
        case (op)
            OP_SW:   return 2'b01;
            OP_BEQ:  return 2'b10;
            OP_JAL:  return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_fsm.sv
// Moore control FSM for the multicycle RISC-V datapath: one state register,
// combinational next-state and per-state datapath controls.
module multicycle_control_fsm
    import multicycle_control_fsm_pkg::*;
#(
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] Op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] ImmSrc,
    output logic       illegal_op,
    output logic [3:0] state
);

    state_t state_q, state_d, cur;
    logic   ready;
    logic   pcupdate, branch;
    logic   irw, memw, regw, ill;

    assign ready = MEM_WAIT_EN ? mem_ready : 1'b1;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (Op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTER;
                    OP_ITYPE:     state_d = S_EXECUTEI;
                    OP_JAL:       state_d = S_JAL;
                    OP_BEQ:       state_d = S_BEQ;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (Op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = ready ? S_FETCH : S_MEMWRITE;
            S_EXECUTER, S_EXECUTEI, S_JAL: state_d = S_ALUWB;
            default:    state_d = S_FETCH;
        endcase
    end

    // Outputs decode from FETCH while in reset, so reset shows FETCH controls
    // with every write strobe suppressed by the rst mask below.
    assign cur = rst ? S_FETCH : state_q;

    always_comb begin
        pcupdate  = 1'b0;
        branch    = 1'b0;
        irw       = 1'b0;
        memw      = 1'b0;
        regw      = 1'b0;
        ill       = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ALUOp     = 2'b00;
        case (cur)
            S_FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                irw       = ready;
                pcupdate  = ready;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (Op)
                    OP_LW, OP_SW, OP_RTYPE, OP_ITYPE, OP_JAL, OP_BEQ: ill = 1'b0;
                    default: ill = 1'b1;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD:  AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'b01;
                regw      = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc = 1'b1;
                memw   = 1'b1;
            end
            S_EXECUTER: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
            end
            S_EXECUTEI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
            end
            S_ALUWB:    regw = 1'b1;
            S_JAL: begin
                ALUSrcA  = 2'b01;
                ALUSrcB  = 2'b10;
                pcupdate = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b01;
                branch  = 1'b1;
            end
            default: ;
        endcase
    end

    assign PCWrite    = (pcupdate | (branch & zero)) & ~rst;
    assign IRWrite    = irw  & ~rst;
    assign MemWrite   = memw & ~rst;
    assign RegWrite   = regw & ~rst;
    assign illegal_op = ill  & ~rst;
    assign ImmSrc     = imm_src(Op);
    assign state      = cur;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench: an instruction-route model predicts every cycle's
// outputs; a negedge monitor pops and compares them against the DUT.
module tb_multicycle_control_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] Op = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, illegal_op;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
    logic [3:0] state;

    always #5 clk = ~clk;

    multicycle_control_fsm #(.MEM_WAIT_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .Op(Op), .zero(zero), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
        .MemWrite(MemWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ImmSrc(ImmSrc),
        .illegal_op(illegal_op), .state(state)
    );

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, adr, irw, memw, regw, ill;
        logic [1:0] res, srca, srcb, aop, imm;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: an instruction is a route of state codes starting at
    // FETCH; memory states (0, 3, 5) advance only when mem_ready is high.
    int route[$];
    int pos = 0;

    function automatic bit legal(input logic [6:0] op);
        return op inside {7'b0000011, 7'b0100011, 7'b0110011,
                          7'b0010011, 7'b1101111, 7'b1100011};
    endfunction

    task automatic build_route(input logic [6:0] op);
        case (op)
            7'b0000011: route = '{0, 1, 2, 3, 4};
            7'b0100011: route = '{0, 1, 2, 5};
            7'b0110011: route = '{0, 1, 6, 7};
            7'b0010011: route = '{0, 1, 8, 7};
            7'b1101111: route = '{0, 1, 9, 7};
            7'b1100011: route = '{0, 1, 10};
            default:    route = '{0, 1};
        endcase
    endtask

    function automatic logic [1:0] ref_imm(input logic [6:0] op);
        if (op == 7'b0100011) return 2'b01;
        if (op == 7'b1100011) return 2'b10;
        if (op == 7'b1101111) return 2'b11;
        return 2'b00;
    endfunction

    function automatic obs_t ref_out(input int code, input logic r, input logic [6:0] op,
                                     input logic z, input logic mr);
        obs_t o;
        o = '0;
        o.imm = ref_imm(op);
        o.st  = r ? 4'd0 : 4'(code);
        if (r || code == 0) begin
            o.srcb = 2'b10;
            o.res  = 2'b10;
            o.irw  = r ? 1'b0 : mr;
            o.pcw  = r ? 1'b0 : mr;
            return o;
        end
        case (code)
            1:  begin o.srca = 2'b01; o.srcb = 2'b01; o.ill = !legal(op); end
            2:  begin o.srca = 2'b10; o.srcb = 2'b01; end
            3:  o.adr = 1'b1;
            4:  begin o.res = 2'b01; o.regw = 1'b1; end
            5:  begin o.adr = 1'b1; o.memw = 1'b1; end
            6:  begin o.srca = 2'b10; o.aop = 2'b10; end
            7:  o.regw = 1'b1;
            8:  begin o.srca = 2'b10; o.srcb = 2'b01; o.aop = 2'b10; end
            9:  begin o.srca = 2'b01; o.srcb = 2'b10; o.pcw = 1'b1; end
            10: begin o.srca = 2'b10; o.aop = 2'b01; o.pcw = z; end
            default: ;
        endcase
        return o;
    endfunction

    function automatic int cur_code();
        return route[pos];
    endfunction

    // One clock cycle: drive inputs, queue the prediction, advance the model.
    task automatic cyc(input logic r, input logic [6:0] op, input logic z, input logic mr);
        int code;
        @(posedge clk);
        #1;
        rst = r; Op = op; zero = z; mem_ready = mr;
        code = cur_code();
        if (code == 0) build_route(op);
        exp_q.push_back(ref_out(code, r, op, z, mr));
        if (r) begin
            route = '{0};
            pos = 0;
        end else if ((code == 0 || code == 3 || code == 5) && !mr) begin
            pos = pos;
        end else begin
            pos++;
            if (pos >= route.size()) begin
                route = '{0};
                pos = 0;
            end
        end
    endtask

    // Run one instruction to completion, stalling the data-memory state nstall cycles.
    task automatic instr(input logic [6:0] op, input logic z, input int nstall);
        int left;
        left = nstall;
        for (int i = 0; i < 40; i++) begin
            if ((cur_code() == 3 || cur_code() == 5) && left > 0) begin
                left--;
                cyc(1'b0, op, z, 1'b0);
            end else begin
                cyc(1'b0, op, z, 1'b1);
            end
            if (pos == 0) break;
        end
    endtask

    always @(negedge clk) begin
        obs_t e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a.st = state; a.pcw = PCWrite; a.adr = AdrSrc; a.irw = IRWrite;
            a.memw = MemWrite; a.regw = RegWrite; a.ill = illegal_op;
            a.res = ResultSrc; a.srca = ALUSrcA; a.srcb = ALUSrcB;
            a.aop = ALUOp; a.imm = ImmSrc;
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL outputs t=%0t act st=%0d pcw=%b adr=%b irw=%b mw=%b rw=%b ill=%b res=%b a=%b b=%b aop=%b imm=%b exp st=%0d pcw=%b adr=%b irw=%b mw=%b rw=%b ill=%b res=%b a=%b b=%b aop=%b imm=%b",
                         $time, a.st, a.pcw, a.adr, a.irw, a.memw, a.regw, a.ill, a.res, a.srca, a.srcb, a.aop, a.imm,
                         e.st, e.pcw, e.adr, e.irw, e.memw, e.regw, e.ill, e.res, e.srca, e.srcb, e.aop, e.imm);
            end
            checks++;
            if ($countones({RegWrite, MemWrite, IRWrite}) > 1) begin
                errors++;
                $display("FAIL onehot_writes t=%0t act rw/mw/irw=%b%b%b exp at most one set",
                         $time, RegWrite, MemWrite, IRWrite);
            end
        end
    end

    initial begin
        logic [6:0] rop;
        logic [6:0] legal_ops [6];
        legal_ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111, 7'b1100011};
        route = '{0};
        pos = 0;
        rop = 7'b0000011;

        cyc(1'b1, 7'b0000011, 1'b0, 1'b1);
        cyc(1'b1, 7'b0000011, 1'b0, 1'b1);
        instr(7'b0000011, 1'b0, 0);                 // lw: 0,1,2,3,4
        instr(7'b0100011, 1'b0, 3);                 // sw with 3-cycle memory stall
        instr(7'b1100011, 1'b1, 0);                 // beq taken
        instr(7'b1100011, 1'b0, 0);                 // beq not taken
        instr(7'b0000000, 1'b0, 0);                 // illegal opcode
        instr(7'b1101111, 1'b0, 0);                 // jal
        instr(7'b0110011, 1'b1, 0);
        instr(7'b0010011, 1'b0, 0);
        cyc(1'b0, 7'b0000011, 1'b0, 1'b0);          // FETCH stall
        instr(7'b0000011, 1'b0, 0);

        // Reset landing in a MEMREAD stall.
        cyc(1'b0, 7'b0000011, 1'b0, 1'b1);
        cyc(1'b0, 7'b0000011, 1'b0, 1'b1);
        cyc(1'b0, 7'b0000011, 1'b0, 1'b1);
        cyc(1'b0, 7'b0000011, 1'b0, 1'b0);
        cyc(1'b0, 7'b0000011, 1'b0, 1'b0);
        cyc(1'b1, 7'b0000011, 1'b0, 1'b0);
        cyc(1'b1, 7'b0000011, 1'b1, 1'b1);
        instr(7'b0000011, 1'b0, 1);

        for (int n = 0; n < 3000; n++) begin
            if (cur_code() == 0) begin
                case ($urandom_range(0, 7))
                    6:       rop = 7'b0000000;
                    7:       rop = 7'($urandom);
                    default: rop = legal_ops[$urandom_range(0, 5)];
                endcase
            end
            cyc(($urandom_range(0, 79) == 0), rop, 1'($urandom), ($urandom_range(0, 3) != 0));
        end

        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain act=%0d pending exp=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control_fsm.md
MULTICYCLE_CONTROL_FSM -- requirements
Module: multicycle_control_fsm

Interface
REQ-001 SHALL have parameter MEM_WAIT_EN, default 1: when 1, mem_ready stalls memory states; when 0, mem_ready is ignored (treated as 1).
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-004 SHALL have port Op, input, 7, opcode field of the instruction register.
REQ-005 SHALL have port zero, input, 1, ALU zero flag.
REQ-006 SHALL have port mem_ready, input, 1, memory completes the current access this cycle.
REQ-007 SHALL have outputs PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, each 1 bit: PC load, address mux select (0 = PC, 1 = ALU result), IR load, store strobe, register-file write.
REQ-008 SHALL have outputs ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, each 2 bits: datapath mux selects and ALU-decoder class.
REQ-009 SHALL have output illegal_op, 1 bit: single-cycle pulse on an unsupported opcode.
REQ-010 SHALL have output state, 4 bits: current state encoding, for debug.

Function
REQ-011 SHALL be a Moore FSM with encodings FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, ALUWB=7, EXECUTEI=8, JAL=9, BEQ=10; codes 11-15 SHALL return to FETCH.
REQ-012 SHALL transition from FETCH to DECODE when mem_ready=1, else hold in FETCH.
REQ-013 SHALL transition from DECODE by Op:
- 0000011 or 0100011 -> MEMADR
- 0110011 -> EXECUTER
- 0010011 -> EXECUTEI
- 1101111 -> JAL
- 1100011 -> BEQ
- any other Op -> FETCH, with illegal_op=1 for that DECODE cycle only.
REQ-014 SHALL transition from MEMADR to MEMREAD if Op=0000011, else to MEMWRITE.
REQ-015 SHALL transition MEMREAD->MEMWB when mem_ready=1 (else hold), and MEMWB->FETCH.
REQ-016 SHALL transition MEMWRITE->FETCH when mem_ready=1, else hold.
REQ-017 SHALL transition EXECUTER->ALUWB, EXECUTEI->ALUWB, JAL->ALUWB, ALUWB->FETCH and BEQ->FETCH unconditionally.
REQ-018 SHALL drive every unlisted output bit to 0 in each state; per-state values:
- FETCH: ALUSrcB=10, ResultSrc=10, IRWrite=mem_ready, PCUpdate=mem_ready.
- DECODE: ALUSrcA=01, ALUSrcB=01.
- MEMADR: ALUSrcA=10, ALUSrcB=01.
- MEMREAD: AdrSrc=1.
- MEMWB: ResultSrc=01, RegWrite=1.
- MEMWRITE: AdrSrc=1, MemWrite=1, held high until mem_ready.
- EXECUTER: ALUSrcA=10, ALUOp=10.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
- ALUWB: RegWrite=1.
- JAL: ALUSrcA=01, ALUSrcB=10, PCUpdate=1.
- BEQ: ALUSrcA=10, ALUOp=01, Branch=1.
REQ-019 SHALL compute PCWrite = PCUpdate OR (Branch AND zero); PCUpdate and Branch are internal signals only.
REQ-020 SHALL decode ImmSrc combinationally from Op in every state: 0000011/0010011 -> 00, 0100011 -> 01, 1100011 -> 10, 1101111 -> 11, otherwise 00.
REQ-021 SHALL assert at most one of RegWrite, MemWrite, IRWrite in any cycle.
REQ-022 SHALL give per-instruction latency with mem_ready always 1: lw 5, sw 4, R/I-type 4, jal 4, beq 3 cycles.

Reset
REQ-023 SHALL load state=FETCH on any clk edge with rst=1, including mid-instruction or mid-stall.
REQ-024 SHALL force PCWrite, IRWrite, MemWrite, RegWrite and illegal_op to 0 while rst=1; the other outputs SHALL take their FETCH values.
REQ-025 SHALL perform the first fetch in the cycle after rst deasserts.

Structure
REQ-026 SHALL take opcode constants and state encodings from a shared header riscv_defs.vh, also used by the decoders.
REQ-027 SHALL consist of one state register plus next-state and output combinational logic; no sub-modules.
REQ-028 SHALL leave ALUOp to feed the existing ALU decoder externally; ALUControl generation is not part of this block.

Verification
REQ-029 SHALL cover: rst then Op=0000011, mem_ready=1 -> states 0,1,2,3,4,0; RegWrite=1 only in state 4; ResultSrc=01 there.
REQ-030 SHALL cover: Op=0100011 with mem_ready=0 for 3 cycles in MEMWRITE -> MemWrite high 4 cycles, then FETCH; RegWrite never 1.
REQ-031 SHALL cover: Op=1100011 with zero=1 -> PCWrite=1 in BEQ; repeated with zero=0 -> PCWrite=0; both return to FETCH after 3 cycles.
REQ-032 SHALL cover: Op=0000000 -> illegal_op=1 for exactly the DECODE cycle, next state FETCH, no write enables asserted.
REQ-033 SHALL cover: rst=1 asserted during the MEMREAD stall -> state=0 next cycle, all write enables 0 while rst=1.
REQ-034 SHALL cover: Op=1101111 -> JAL asserts PCWrite=1 and ALUWB asserts RegWrite=1; latency 4.
